stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Game-flow controller directly upstream of the per-level object stage.
//  Runs the IDLE/PLAYING/result FSM and drives the stage enable and level-advance strobe.
//  Owns the per-stage countdown (oneSecPulse-driven), the money accumulator and the
//  level target, and judges stage pass/fail from money, timer and stage status inputs.
// PARAMETERS
//  NUM_LEVELS   3     number of levels; level index 0..NUM_LEVELS-1
//  MAX_TIME     60    stage countdown reload, seconds (fits 7 bits)
//  BASE_TARGET  100   money target for level 0
//  TARGET_STEP  150   target increment per level
// PORTS
//  clk            in   1   system clock
//  resetN         in   1   async active-low reset
//  startKey       in   1   one-cycle pulse, debounced player start/continue
//  oneSecPulse    in   1   one-cycle pulse, once per second
//  goldValid      in   1   one-cycle pulse: object delivered to miner
//  goldValue      in   8   value of delivered object, sampled when goldValid=1
//  stagePassed    in   1   stage reports all objects collected
//  stageFailed    in   1   stage reports unrecoverable failure
//  pauseKey       in   1   toggle pause (used only with STAGE_PAUSE_EN)
//  stageEnable    out  1   high while PLAYING; level data loads on its rising edge
//  cycleLevel     out  1   one-cycle strobe: advance to next level
//  levelNum       out  4   current level index
//  timerSec       out  7   seconds remaining
//  money          out  16  accumulated money, saturating
//  target         out  16  BASE_TARGET + levelNum*TARGET_STEP (registered)
//  gameState      out  3   encoded FSM state for display muxing
//  gameWon        out  1   high in GAME_WON
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0 except target=BASE_TARGET; all outputs registered.
//  States: IDLE=0, PLAYING=1, STAGE_WON=2, STAGE_LOST=3, GAME_WON=4, PAUSED=5.
//  IDLE: startKey -> PLAYING; money=0, levelNum=0, timerSec=MAX_TIME, same edge.
//  PLAYING: stageEnable=1 (asserted the cycle after the transition edge).
//   oneSecPulse with timerSec>0 -> timerSec-1; never wraps below 0.
//   goldValid -> money += goldValue; saturates at 16'hFFFF.
//   Judge when timerSec==0 or stagePassed: money>=target -> STAGE_WON, else STAGE_LOST.
//   stageFailed -> STAGE_LOST (priority over stagePassed and timer expiry).
//   Same-cycle goldValid and judge event: the judge compares the post-add money.
//  STAGE_WON: startKey: levelNum==NUM_LEVELS-1 -> GAME_WON;
//   else cycleLevel=1 for exactly one cycle, levelNum+1, timerSec=MAX_TIME, -> PLAYING.
//   Money carries over between levels.
//  STAGE_LOST, GAME_WON: startKey -> IDLE. gameWon=1 only in GAME_WON.
//  stageEnable drops the cycle after leaving PLAYING; a win/lose causes a 0-1 re-edge.
//  Inputs are ignored in states where they are not listed.
//  Reset mid-game: immediate return to reset values, no cycleLevel strobe.
// CONFIGURATION
//  STAGE_PAUSE_EN defined: pauseKey in PLAYING -> PAUSED (stageEnable stays 1, timer
//   and money frozen, goldValid ignored); pauseKey in PAUSED -> PLAYING.
//  Not defined: pauseKey ignored; PAUSED state unreachable.
// STRUCTURE
//  game_pkg: state enum (3-bit), default MAX_TIME/BASE_TARGET/TARGET_STEP constants.
//  Sub-module stage_countdown: load, tick, freeze -> timerSec, expired flag.
// TESTING
//  Reset, startKey -> PLAYING, stageEnable=1 next cycle, timerSec=60, levelNum=0.
//  60 oneSecPulse, money 50 < target 100 -> STAGE_LOST; extra pulses keep timerSec=0.
//  goldValue 120 then stagePassed -> STAGE_WON; startKey -> one-cycle cycleLevel,
//   levelNum=1, target=250, money=120.
//  money 0xFFF0 + goldValue 0x20 -> 0xFFFF; stagePassed+stageFailed same cycle -> LOST.
//  Win at level 2 + startKey -> GAME_WON, gameWon=1; startKey -> IDLE.
//  STAGE_PAUSE_EN: pause 5 s of pulses -> timerSec unchanged; unpause resumes.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow types and default constants for the stage sequencer.
// The 3-bit state encoding is visible on gameState for display muxing.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAYING    = 3'd1,
        STAGE_WON  = 3'd2,
        STAGE_LOST = 3'd3,
        GAME_WON   = 3'd4,
        PAUSED     = 3'd5
    } gameState_e;

    localparam int NUM_LEVELS_DEF  = 3;
    localparam int MAX_TIME_DEF    = 60;
    localparam int BASE_TARGET_DEF = 100;
    localparam int TARGET_STEP_DEF = 150;

    function automatic logic [15:0] levelTarget(input logic [3:0] lvl, input int base,
                                                input int step);
        return 16'(base + int'(lvl) * step);
    endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Link between the sequencer and the object stage: the stage reports deliveries and
// status; the sequencer enables the stage and strobes level advances.
interface stage_sequencer_if;

    // goldValid and the stage status bits are single-cycle qualifiers with no
    // back-pressure: the sequencer samples goldValue on every cycle goldValid is high.
    logic        goldValid;
    logic [7:0]  goldValue;
    logic        stagePassed;
    logic        stageFailed;
    logic        stageEnable;
    logic        cycleLevel;

    modport master (
        input  goldValid, goldValue, stagePassed, stageFailed,
        output stageEnable, cycleLevel
    );

    modport slave (
        output goldValid, goldValue, stagePassed, stageFailed,
        input  stageEnable, cycleLevel
    );

endinterface

// File: rtl/stage_countdown.sv
// Per-stage seconds countdown: load reloads, tick decrements unless frozen,
// and the count holds at zero rather than wrapping.
module stage_countdown #(
    parameter int MAX_TIME = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       load,
    input  logic       tick,
    input  logic       freeze,
    output logic [6:0] timerSec,
    output logic       expired
);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timerSec <= '0;
        end else if (load) begin
            timerSec <= 7'(MAX_TIME);
        end else if (tick && !freeze && (timerSec != '0)) begin
            timerSec <= timerSec - 7'd1;
        end
    end

    assign expired = (timerSec == '0);

endmodule

// File: rtl/stage_sequencer.sv
// Game-flow controller: IDLE/PLAYING/result FSM, money, level target and countdown.
// Optional pause support is built when STAGE_PAUSE_EN is defined.
module stage_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS  = NUM_LEVELS_DEF,
    parameter int MAX_TIME    = MAX_TIME_DEF,
    parameter int BASE_TARGET = BASE_TARGET_DEF,
    parameter int TARGET_STEP = TARGET_STEP_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startKey,
    input  logic               oneSecPulse,
    input  logic               pauseKey,
    stage_sequencer_if.master  stageBus,
    output logic [3:0]         levelNum,
    output logic [6:0]         timerSec,
    output logic [15:0]        money,
    output logic [15:0]        target,
    output logic [2:0]         gameState,
    output logic               gameWon
);

    gameState_e  state, nextState;
    logic [16:0] sumWide;
    logic [15:0] moneyAdd, moneyNext;
    logic        loadTimer, advance, lastLevel, timerExpired;
    logic        stageEnableQ, cycleLevelQ;

    stage_countdown #(.MAX_TIME(MAX_TIME)) countdown (
        .clk     (clk),
        .resetN  (resetN),
        .load    (loadTimer),
        .tick    (oneSecPulse),
        .freeze  (state != PLAYING),
        .timerSec(timerSec),
        .expired (timerExpired)
    );

`ifndef STAGE_PAUSE_EN
    logic unusedPauseKey;
    assign unusedPauseKey = pauseKey;
`endif

    always_comb begin
        sumWide   = {1'b0, money} + {9'd0, stageBus.goldValue};
        moneyAdd  = sumWide[16] ? 16'hFFFF : sumWide[15:0];
        lastLevel = (levelNum == 4'(NUM_LEVELS - 1));
        moneyNext = money;
        nextState = state;
        loadTimer = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (startKey) begin
                    nextState = PLAYING;
                    moneyNext = '0;
                    loadTimer = 1'b1;
                end
            end
            PLAYING: begin
                if (stageBus.goldValid) moneyNext = moneyAdd;
                // Judging uses moneyNext so a delivery in the judging cycle still counts.
                if (stageBus.stageFailed) begin
                    nextState = STAGE_LOST;
                end else if (timerExpired || stageBus.stagePassed) begin
                    nextState = (moneyNext >= target) ? STAGE_WON : STAGE_LOST;
`ifdef STAGE_PAUSE_EN
                end else if (pauseKey) begin
                    nextState = PAUSED;
`endif
                end
            end
            STAGE_WON: begin
                if (startKey) begin
                    if (lastLevel) begin
                        nextState = GAME_WON;
                    end else begin
                        nextState = PLAYING;
                        advance   = 1'b1;
                        loadTimer = 1'b1;
                    end
                end
            end
            STAGE_LOST, GAME_WON: begin
                if (startKey) nextState = IDLE;
            end
`ifdef STAGE_PAUSE_EN
            PAUSED: begin
                if (pauseKey) nextState = PLAYING;
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            money        <= '0;
            levelNum     <= '0;
            target       <= 16'(BASE_TARGET);
            stageEnableQ <= 1'b0;
            cycleLevelQ  <= 1'b0;
            gameWon      <= 1'b0;
        end else begin
            state        <= nextState;
            money        <= moneyNext;
            cycleLevelQ  <= advance;
            stageEnableQ <= (nextState == PLAYING) || (nextState == PAUSED);
            gameWon      <= (nextState == GAME_WON);
            if ((state == IDLE) && startKey) begin
                levelNum <= '0;
                target   <= 16'(BASE_TARGET);
            end else if (advance) begin
                levelNum <= levelNum + 4'd1;
                target   <= levelTarget(levelNum + 4'd1, BASE_TARGET, TARGET_STEP);
            end
        end
    end

    assign gameState            = state;
    assign stageBus.stageEnable = stageEnableQ;
    assign stageBus.cycleLevel  = cycleLevelQ;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed game scenarios followed by random
// play, every cycle compared against a behavioural game model.
module tb_stage_sequencer;

  localparam int MAX_T = 60;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startKey = 1'b0, oneSecPulse = 1'b0, pauseKey = 1'b0;
  logic [3:0]  levelNum;
  logic [6:0]  timerSec;
  logic [15:0] money, target;
  logic [2:0]  gameState;
  logic        gameWon;

  stage_sequencer_if bus();

  stage_sequencer dut (
    .clk(clk), .resetN(resetN), .startKey(startKey), .oneSecPulse(oneSecPulse),
    .pauseKey(pauseKey), .stageBus(bus.master), .levelNum(levelNum), .timerSec(timerSec),
    .money(money), .target(target), .gameState(gameState), .gameWon(gameWon)
  );

  // clock / reset
  always #5 clk = ~clk;

  int assertCnt = 0;
  int failCnt = 0;

  // reference game model: 0 idle, 1 playing, 2 won, 3 lost, 4 game won, 5 paused
  int mState, mLevel, mTime, mMoney;
  bit mCycle;

  function automatic int targetOf(input int lvl);
    return 100 + 150 * lvl;
  endfunction

  task automatic model_reset();
    mState = 0; mLevel = 0; mTime = 0; mMoney = 0; mCycle = 0;
  endtask

  task automatic model_step();
    int ns = mState;
    int oldTime = mTime;
    mCycle = 0;
    case (mState)
      0: if (startKey) begin ns = 1; mMoney = 0; mLevel = 0; mTime = MAX_T; end
      1: begin
        if (bus.goldValid) mMoney = (mMoney + int'(bus.goldValue) > 65535) ? 65535
                                    : mMoney + int'(bus.goldValue);
        if (bus.stageFailed) ns = 3;
        else if (oldTime == 0 || bus.stagePassed) ns = (mMoney >= targetOf(mLevel)) ? 2 : 3;
`ifdef STAGE_PAUSE_EN
        else if (pauseKey) ns = 5;
`endif
        if (oneSecPulse && oldTime > 0) mTime = oldTime - 1;
      end
      2: if (startKey) begin
        if (mLevel == 2) ns = 4;
        else begin ns = 1; mLevel++; mTime = MAX_T; mCycle = 1; end
      end
      3, 4: if (startKey) ns = 0;
      5: if (pauseKey) ns = 1;
      default: ns = 0;
    endcase
    mState = ns;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("gameState", 32'(gameState), 32'(mState));
    check("stageEnable", 32'(bus.stageEnable), 32'(mState == 1 || mState == 5));
    check("cycleLevel", 32'(bus.cycleLevel), 32'(mCycle));
    check("levelNum", 32'(levelNum), 32'(mLevel));
    check("timerSec", 32'(timerSec), 32'(mTime));
    check("money", 32'(money), 32'(mMoney));
    check("target", 32'(target), 32'(targetOf(mLevel)));
    check("gameWon", 32'(gameWon), 32'(mState == 4));
  endtask

  // driver tasks
  task automatic clear_in();
    startKey = 0; oneSecPulse = 0; pauseKey = 0;
    bus.goldValid = 0; bus.goldValue = '0; bus.stagePassed = 0; bus.stageFailed = 0;
  endtask

  task automatic run();
    model_step();
    @(posedge clk); #1;
    clear_in();
    check_all();
  endtask

  task automatic press_start();  startKey = 1; run(); endtask
  task automatic pulse();        oneSecPulse = 1; run(); endtask
  task automatic pass_stage();   bus.stagePassed = 1; run(); endtask
  task automatic gold(input int v); bus.goldValid = 1; bus.goldValue = 8'(v); run(); endtask

  initial begin
    clear_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) resetN = 1;
    @(posedge clk); #1 check_all();

    // start, then lose by timeout with money 50
    press_start();
    check("stageEnable_on_start", 32'(bus.stageEnable), 32'd1);
    check("timer_reload", 32'(timerSec), 32'(MAX_T));
    gold(50);
    repeat (MAX_T) pulse();
    check("timer_zero", 32'(timerSec), 32'd0);
    run();
    check("timeout_lost", 32'(gameState), 32'd3);
    repeat (3) pulse();
    check("timer_no_wrap", 32'(timerSec), 32'd0);

    // win level 0, advance to level 1 with carried money
    press_start();
    press_start();
    gold(120);
    pass_stage();
    check("stage_won", 32'(gameState), 32'd2);
    press_start();
    check("cycle_strobe", 32'(bus.cycleLevel), 32'd1);
    check("target_lvl1", 32'(target), 32'd250);
    check("money_carry", 32'(money), 32'd120);
    run();
    check("cycle_one_shot", 32'(bus.cycleLevel), 32'd0);

    // delivery in the judging cycle counts: 120+130 reaches 250
    bus.goldValid = 1; bus.goldValue = 8'd130; bus.stagePassed = 1; run();
    check("same_cycle_judge", 32'(gameState), 32'd2);
    press_start();

    // level 2 needs 400: money 250+150, then win the game
    gold(150);
    pass_stage();
    press_start();
    check("game_won", 32'(gameWon), 32'd1);
    press_start();
    check("back_idle", 32'(gameState), 32'd0);

    // saturation, then failure beats pass in the same cycle
    press_start();
    repeat (256) gold(255);
    gold(240);
    check("money_fff0", 32'(money), 32'hFFF0);
    gold(32);
    check("money_sat", 32'(money), 32'hFFFF);
    bus.stagePassed = 1; bus.stageFailed = 1; run();
    check("fail_priority", 32'(gameState), 32'd3);
    press_start();

`ifdef STAGE_PAUSE_EN
    press_start();
    pulse();
    pauseKey = 1; run();
    check("paused", 32'(gameState), 32'd5);
    repeat (5) pulse();
    gold(9);
    check("pause_freeze", 32'(timerSec), 32'(MAX_T - 1));
    pauseKey = 1; run();
    pulse();
    check("pause_resume", 32'(timerSec), 32'(MAX_T - 2));
`endif

    // random play
    for (int i = 0; i < 1500; i++) begin
      startKey         = ($urandom_range(0, 9) == 0);
      oneSecPulse      = ($urandom_range(0, 3) == 0);
      bus.goldValid    = ($urandom_range(0, 2) == 0);
      bus.goldValue    = 8'($urandom_range(0, 255));
      bus.stagePassed  = ($urandom_range(0, 39) == 0);
      bus.stageFailed  = ($urandom_range(0, 79) == 0);
      pauseKey         = ($urandom_range(0, 19) == 0);
      run();
    end

    // reset mid-game returns everything to reset values at once
    press_start();
    gold(77);
    resetN = 0;
    model_reset();
    #2 check_all();
    @(negedge clk) resetN = 1;
    press_start();
    check("restart_after_reset", 32'(gameState), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
